cnn_pool: RTL and testbench

Downstream compute stage of the CNN on-chip feature-map RAM: a bus-master engine that reads a single-channel 8-bit feature map from the memory, applies 2x2/stride-2 max-pooling, and writes the pooled map back to a second region of the same memory. It drives the memory's chipselect/read/write/address/writedata port and consumes its registered read data (1-cycle latency). Software or the layer sequencer starts it once per pooling layer.

---
 rtl/cnn_pkg.sv | 17 +
 rtl/cnn_pool_addr_gen.sv | 91 +++++++++
 rtl/cnn_pool.sv | 166 ++++++++++++++++
 tb/tb_cnn_pool.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN compute stages: bus/pixel/dimension widths
// and the pooling engine state encoding.
package cnn_pkg;

  localparam int ADDR_W = 19;  // feature RAM address width
  localparam int DATA_W = 8;   // signed pixel width
  localparam int DIM_W  = 8;   // width/height field width

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CAPT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } pool_state_t;

endpackage

// File: rtl/cnn_pool_addr_gen.sv
// Address generator for the 2x2/stride-2 pooling engine.
// Walks output pixels in raster order and produces the four window read
// addresses plus the write address using accumulators only: the source row
// base advances by 2*W per output row, the destination row base by Wo.
// k holds the window sample whose read is issued next; the k=0 read of the
// very first window is issued by the top together with load, so load sets k=1.
module cnn_pool_addr_gen #(
  parameter int ADDR_W = cnn_pkg::ADDR_W,
  parameter int DIM_W  = cnn_pkg::DIM_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-2:0]  out_h,
  input  logic              rd_step,
  input  logic              pix_step,
  output logic [1:0]        k,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              last_pix
);

  localparam int PAD = ADDR_W - DIM_W;
  localparam logic [DIM_W-2:0] ONE_O = (DIM_W-1)'(1);

  logic [DIM_W-1:0]  w_q;
  logic [DIM_W-2:0]  wo_q;
  logic [DIM_W-2:0]  ho_q;
  logic [DIM_W-2:0]  ox_q;
  logic [DIM_W-2:0]  oy_q;
  logic [1:0]        k_q;
  logic [ADDR_W-1:0] row_q;      // src_base + 2*oy*W
  logic [ADDR_W-1:0] dst_row_q;  // dst_base + oy*Wo

  logic [ADDR_W-1:0] w_ext;
  logic [ADDR_W-1:0] wo_ext;
  logic [ADDR_W-1:0] ox_ext;
  logic [ADDR_W-1:0] col_ext;

  assign w_ext   = {{PAD{1'b0}}, w_q};
  assign wo_ext  = {{(PAD+1){1'b0}}, wo_q};
  assign ox_ext  = {{(PAD+1){1'b0}}, ox_q};
  assign col_ext = {{PAD{1'b0}}, ox_q, k_q[0]};  // 2*ox + dx

  // Counter and accumulator update: load on job start, step k per read,
  // advance the output position after each capture.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      w_q       <= '0;
      wo_q      <= '0;
      ho_q      <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      k_q       <= '0;
      row_q     <= '0;
      dst_row_q <= '0;
    end else if (load) begin
      w_q       <= width;
      wo_q      <= width[DIM_W-1:1];
      ho_q      <= out_h;
      ox_q      <= '0;
      oy_q      <= '0;
      k_q       <= 2'd1;
      row_q     <= src_base;
      dst_row_q <= dst_base;
    end else begin
      if (rd_step) k_q <= k_q + 2'd1;
      if (pix_step) begin
        if (ox_q == wo_q - ONE_O) begin
          ox_q      <= '0;
          oy_q      <= oy_q + ONE_O;
          row_q     <= row_q + w_ext + w_ext;
          dst_row_q <= dst_row_q + wo_ext;
        end else begin
          ox_q <= ox_q + ONE_O;
        end
      end
    end
  end

  assign k        = k_q;
  assign rd_addr  = row_q + (k_q[1] ? w_ext : '0) + col_ext;
  assign wr_addr  = dst_row_q + ox_ext;
  assign last_pix = (ox_q == wo_q - ONE_O) && (oy_q == ho_q - ONE_O);

endmodule

// File: rtl/cnn_pool.sv
// 2x2/stride-2 max-pooling bus-master engine.
// Reads a signed 8-bit single-channel map from the feature RAM, pools it and
// writes the result to a second region. 6 cycles per output pixel:
// READ x4, CAPT, WRITE. All bus outputs are registered.
// Build option: define CNN_POOL_RELU_EN to clamp negative results to zero
// (fused ReLU); timing is the same either way.
module cnn_pool #(
  parameter int ADDR_W = cnn_pkg::ADDR_W,
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int DIM_W  = cnn_pkg::DIM_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  output logic              busy,
  output logic              done,
  output logic              mem_chipselect,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  import cnn_pkg::*;

  localparam logic [DIM_W-1:0] TWO_D = DIM_W'(2);

  pool_state_t state_q, state_d;

  logic              deg_job;
  logic              starting;
  logic              agen_load;
  logic              rd_step;
  logic              pix_step;
  logic [1:0]        agen_k;
  logic [ADDR_W-1:0] agen_rd_addr;
  logic [ADDR_W-1:0] agen_wr_addr;
  logic              last_pix;
  logic              last_q;

  logic signed [DATA_W-1:0] sample;
  logic signed [DATA_W-1:0] max_q;
  logic signed [DATA_W-1:0] pool_max;
  logic signed [DATA_W-1:0] wr_val;

  logic              busy_d, done_d, rd_d, wr_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  // Wo or Ho of zero means there is nothing to pool.
  assign deg_job   = (width < TWO_D) || (height < TWO_D);
  assign starting  = (state_q == IDLE) && start;
  assign agen_load = starting && !deg_job;
  assign rd_step   = (state_d == READ) && (state_q != IDLE);
  assign pix_step  = (state_q == CAPT);

  cnn_pool_addr_gen #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (agen_load),
    .src_base (src_base),
    .dst_base (dst_base),
    .width    (width),
    .out_h    (height[DIM_W-1:1]),
    .rd_step  (rd_step),
    .pix_step (pix_step),
    .k        (agen_k),
    .rd_addr  (agen_rd_addr),
    .wr_addr  (agen_wr_addr),
    .last_pix (last_pix)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; in READ, agen_k wraps to 0 once the k=3 read is out.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = deg_job ? DONE : READ;
      READ:    if (agen_k == 2'd0) state_d = CAPT;
      CAPT:    state_d = WRITE;
      WRITE:   state_d = last_q ? DONE : READ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Signed running max including the sample arriving this cycle.
  assign sample   = $signed(mem_readdata);
  assign pool_max = (sample > max_q) ? sample : max_q;

`ifdef CNN_POOL_RELU_EN
  assign wr_val = pool_max[DATA_W-1] ? '0 : pool_max;
`else
  assign wr_val = pool_max;
`endif

  // Sample capture: read data lags its strobe by one cycle, so the READ with
  // agen_k==2 sees sample 0 (initialise), later READs and CAPT fold in the rest.
  always_ff @(posedge clk) begin
    if (reset) begin
      max_q  <= '0;
      last_q <= 1'b0;
    end else if (state_q == READ) begin
      if (agen_k == 2'd2)      max_q <= sample;
      else if (agen_k != 2'd1) max_q <= pool_max;
    end else if (state_q == CAPT) begin
      max_q  <= pool_max;
      last_q <= last_pix;
    end
  end

  // Output decode: values the bus registers take for the state being entered.
  always_comb begin
    busy_d  = (state_d == READ) || (state_d == CAPT) || (state_d == WRITE);
    done_d  = (state_d == DONE);
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    if (state_d == READ) begin
      rd_d   = 1'b1;
      addr_d = (state_q == IDLE) ? src_base : agen_rd_addr;
    end else if (state_d == WRITE) begin
      wr_d    = 1'b1;
      addr_d  = agen_wr_addr;
      wdata_d = wr_val;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      mem_chipselect <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_writedata  <= '0;
    end else begin
      busy           <= busy_d;
      done           <= done_d;
      mem_chipselect <= rd_d | wr_d;
      mem_read       <= rd_d;
      mem_write      <= wr_d;
      mem_address    <= addr_d;
      mem_writedata  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_cnn_pool.sv
// Testbench for cnn_pool: memory model with 1-cycle read latency, reference
// pooling model filling read/write scoreboards, and a negedge monitor that
// compares every bus access against them.
module tb_cnn_pool;

  localparam int AW       = 19;
  localparam int DW       = 8;
  localparam int MW       = 8;
  localparam int MEM_SIZE = 1 << AW;
  localparam int MASK     = MEM_SIZE - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] src_base, dst_base;
  logic [MW-1:0] width, height;
  logic          busy, done;
  logic          mem_chipselect, mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;

  always #5 clk = ~clk;

  cnn_pool dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .src_base       (src_base),
    .dst_base       (dst_base),
    .width          (width),
    .height         (height),
    .busy           (busy),
    .done           (done),
    .mem_chipselect (mem_chipselect),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_writedata  (mem_writedata),
    .mem_readdata   (mem_readdata)
  );

  // Memory model plus a preload port used only while the engine is idle.
  logic [DW-1:0] mem     [0:MEM_SIZE-1];
  bit            written [0:MEM_SIZE-1];
  logic          pl_we = 1'b0;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge clk) begin
    if (mem_read) mem_readdata <= mem[mem_address];
    if (mem_write) begin
      mem[mem_address]     <= mem_writedata;
      written[mem_address] <= 1'b1;
    end
    if (pl_we) begin
      mem[pl_addr]     <= pl_data;
      written[pl_addr] <= 1'b0;
    end
  end

  // Reference copy of source data and the scoreboards.
  logic [7:0] ref_mem [int];
  typedef struct { int addr; int data; } wr_t;
  int  exp_rd[$];
  wr_t exp_wr[$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_reads = 0;
  int n_writes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: every access is checked against the scoreboards.
  always @(negedge clk) begin
    wr_t e;
    int  a;
    if (mem_chipselect || mem_read || mem_write) begin
      check("chipselect", {31'd0, mem_chipselect}, {31'd0, mem_read | mem_write});
      if (mem_read && mem_write) fail_now("read_and_write_together");
    end
    if (mem_read) begin
      n_reads++;
      if (exp_rd.size() == 0) fail_now("unexpected_read");
      else begin
        a = exp_rd.pop_front();
        check("rd_addr", 32'(mem_address), a);
      end
    end
    if (mem_write) begin
      n_writes++;
      if (exp_wr.size() == 0) fail_now("unexpected_write");
      else begin
        e = exp_wr.pop_front();
        check("wr_addr", 32'(mem_address), e.addr);
        check("wr_data", 32'(mem_writedata), e.data);
      end
    end
  end

  task automatic poke(input int a, input logic [7:0] d);
    int am;
    am = a & MASK;
    ref_mem[am] = d;
    pl_addr = am[AW-1:0];
    pl_data = d;
    pl_we   = 1'b1;
    @(posedge clk); #2;
    pl_we   = 1'b0;
  endtask

  // Reference model: pooling computed straight from the window definition.
  task automatic model_job(input int src, input int dst, input int w, input int h);
    int wo, ho, a, mx, v;
    logic signed [7:0] s;
    wo = w / 2;
    ho = h / 2;
    for (int oy = 0; oy < ho; oy++) begin
      for (int ox = 0; ox < wo; ox++) begin
        mx = 0;
        for (int k = 0; k < 4; k++) begin
          a = (src + (2*oy + k/2)*w + 2*ox + k%2) & MASK;
          exp_rd.push_back(a);
          s = ref_mem.exists(a) ? ref_mem[a] : 8'h00;
          v = int'(s);
          if (k == 0 || v > mx) mx = v;
        end
`ifdef CNN_POOL_RELU_EN
        if (mx < 0) mx = 0;
`endif
        exp_wr.push_back('{(dst + oy*wo + ox) & MASK, mx & 8'hFF});
      end
    end
  endtask

  // Runs one job from its start cycle (cycle 0); optionally pulses start
  // again with other parameters at cycle restart_at.
  task automatic run_job(input int src, input int dst, input int w, input int h,
                         input int restart_at);
    int n, exp_done, rd0, wr0, cyc, busy_cnt;
    bit seen;
    n        = (w/2) * (h/2);
    exp_done = (n == 0) ? 1 : 6*n + 1;
    rd0      = n_reads;
    wr0      = n_writes;
    busy_cnt = 0;
    seen     = 1'b0;
    model_job(src, dst, w, h);
    src_base = src[AW-1:0];
    dst_base = dst[AW-1:0];
    width    = w[MW-1:0];
    height   = h[MW-1:0];
    start    = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    cyc   = 1;
    while (cyc <= exp_done + 10) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      start = (cyc == restart_at);
      if (cyc == restart_at) begin
        src_base = 19'd500;
        dst_base = 19'd600;
        width    = 8'd2;
        height   = 8'd2;
      end
      @(posedge clk); #2;
      cyc++;
    end
    start = 1'b0;
    if (!seen) fail_now("done_timeout");
    else check("done_cycle", cyc, exp_done);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    check("busy_cycles", busy_cnt, 6*n);
    @(posedge clk); #2;
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("read_count", n_reads - rd0, 4*n);
    check("write_count", n_writes - wr0, n);
    check("rd_queue_empty", exp_rd.size(), 0);
    check("wr_queue_empty", exp_wr.size(), 0);
    exp_rd.delete();
    exp_wr.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_cs"},   {31'd0, mem_chipselect}, 32'd0);
    check({tag, "_rd"},   {31'd0, mem_read}, 32'd0);
    check({tag, "_wr"},   {31'd0, mem_write}, 32'd0);
    check({tag, "_addr"}, 32'(mem_address), 32'd0);
    check({tag, "_wdata"}, 32'(mem_writedata), 32'd0);
  endtask

  initial begin
    int rd0, w, h, src, dst;
    logic [7:0] sgn_a [4];
    logic [7:0] sgn_b [4];
    logic [7:0] exp_sgn;
    sgn_a = '{8'h80, 8'hF0, 8'hFF, 8'h85};
    sgn_b = '{8'h7F, 8'h80, 8'h01, 8'h02};

    reset    = 1'b1;
    start    = 1'b0;
    src_base = '0;
    dst_base = '0;
    width    = '0;
    height   = '0;
    repeat (3) @(posedge clk);
    #2;
    check_outputs_zero("reset_state");
    reset = 1'b0;
    @(posedge clk); #2;

    // 4x4 ramp: expect 5,7,13,15 at 100..103, done at cycle 25.
    for (int i = 0; i < 16; i++) poke(i, 8'(i));
    run_job(0, 100, 4, 4, -1);
    check("ramp_100", 32'(mem[100]), 32'd5);
    check("ramp_101", 32'(mem[101]), 32'd7);
    check("ramp_102", 32'(mem[102]), 32'd13);
    check("ramp_103", 32'(mem[103]), 32'd15);

    // Signed comparisons.
`ifdef CNN_POOL_RELU_EN
    exp_sgn = 8'h00;
`else
    exp_sgn = 8'hFF;
`endif
    for (int i = 0; i < 4; i++) poke(300 + i, sgn_a[i]);
    run_job(300, 350, 2, 2, -1);
    check("signed_neg", 32'(mem[350]), 32'(exp_sgn));
    for (int i = 0; i < 4; i++) poke(310 + i, sgn_b[i]);
    run_job(310, 360, 2, 2, -1);
    check("signed_pos", 32'(mem[360]), 32'h7F);

    // Odd dimensions: 5x3 -> 2 outputs, done at cycle 13.
    for (int i = 0; i < 15; i++) poke(400 + i, 8'($urandom));
    run_job(400, 500, 5, 3, -1);

    // Degenerate: no accesses, done at cycle 1.
    run_job(600, 700, 1, 8, -1);
    run_job(600, 700, 8, 0, -1);

    // Second start during a job is ignored.
    for (int i = 0; i < 4; i++) poke(100 + i, 8'h00);
    run_job(0, 100, 4, 4, 3);
    check("restart_100", 32'(mem[100]), 32'd5);
    check("restart_103", 32'(mem[103]), 32'd15);

    // Reset at cycle 10 of a 4x4 job.
    for (int i = 0; i < 4; i++) poke(100 + i, 8'hEE);
    model_job(0, 100, 4, 4);
    rd0      = n_reads;
    src_base = '0;
    dst_base = 19'd100;
    width    = 8'd4;
    height   = 8'd4;
    start    = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk); #2;
    end
    reset = 1'b1;
    @(posedge clk); #2;
    check_outputs_zero("after_reset");
    check("reset_reads_left", exp_rd.size(), 8);
    check("reset_writes_left", exp_wr.size(), 3);
    reset = 1'b0;
    exp_rd.delete();
    exp_wr.delete();
    repeat (10) @(posedge clk);
    #2;
    check("reset_idle_busy", {31'd0, busy}, 32'd0);
    check("reset_read_total", n_reads - rd0, 8);
    check("reset_kept_100", 32'(mem[100]), 32'd5);
    check("reset_unwritten_101", {31'd0, written[101]}, 32'd0);
    run_job(0, 200, 4, 4, -1);
    check("fresh_200", 32'(mem[200]), 32'd5);
    check("fresh_203", 32'(mem[203]), 32'd15);

    // Randomised jobs.
    for (int j = 0; j < 6; j++) begin
      w   = $urandom_range(0, 11);
      h   = $urandom_range(0, 11);
      src = 1000 + 200*j;
      dst = 20000 + 200*j;
      for (int i = 0; i < w*h; i++) poke(src + i, 8'($urandom));
      run_job(src, dst, w, h, -1);
    end

    // Source region wrapping past the top of the address space.
    src = MEM_SIZE - 7;
    for (int i = 0; i < 24; i++) poke(src + i, 8'($urandom));
    run_job(src, 30000, 6, 4, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
